// File: rtl/la_ctrl_pkg.sv
// Shared encodings for the logic-analyzer run controller: FSM states,
// per-channel trigger codes {level, pol, en} and trigger-mode values.
package la_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_EXPORT = 2'd2
    } state_e;

    localparam logic [2:0] TC_OFF  = 3'b000;
    localparam logic [2:0] TC_RISE = 3'b001;
    localparam logic [2:0] TC_FALL = 3'b011;
    localparam logic [2:0] TC_HIGH = 3'b101;
    localparam logic [2:0] TC_LOW  = 3'b111;

    localparam logic [1:0] TM_OR       = 2'd0;
    localparam logic [1:0] TM_AND_ACC  = 2'd1;
    localparam logic [1:0] TM_AND_COIN = 2'd2;

    // Type-button cycle; unknown codes fall back to OFF.
    function automatic logic [2:0] next_code(input logic [2:0] c);
        case (c)
            TC_OFF:  next_code = TC_RISE;
            TC_RISE: next_code = TC_FALL;
            TC_FALL: next_code = TC_HIGH;
            TC_HIGH: next_code = TC_LOW;
            default: next_code = TC_OFF;
        endcase
    endfunction

endpackage

// File: rtl/la_run_ctrl_if.sv
// Button/streamer/core handshake bundle for la_run_ctrl. The master side
// drives the pulses and status levels; the controller is the slave.
interface la_run_ctrl_if #(parameter int NUM_CH = 8);
    localparam int IDX_W = $clog2(NUM_CH);

    logic              btn_run_pulse;
    logic              btn_channel_pulse;
    logic              btn_type_pulse;
    logic              btn_mode_pulse;
    logic              btn_shot_pulse;
    logic              capture_done;
    logic              uart_busy;
    logic              uart_done;
    logic              trigger_enable;
    logic [NUM_CH-1:0] trigger_mask;
    logic [NUM_CH-1:0] edge_trigger;
    logic [NUM_CH-1:0] trigger_type;
    logic [1:0]        trigger_mode;
    logic              cfg_changed;
    logic              uart_start;
    logic              clear_done;
    logic              single_shot;
    logic [IDX_W-1:0]  cfg_channel;
    logic [2:0]        curr_cfg;
    logic [1:0]        state_o;
    logic              export_err;

    modport master (
        output btn_run_pulse, btn_channel_pulse, btn_type_pulse, btn_mode_pulse,
               btn_shot_pulse, capture_done, uart_busy, uart_done,
        input  trigger_enable, trigger_mask, edge_trigger, trigger_type, trigger_mode,
               cfg_changed, uart_start, clear_done, single_shot, cfg_channel,
               curr_cfg, state_o, export_err
    );

    modport slave (
        input  btn_run_pulse, btn_channel_pulse, btn_type_pulse, btn_mode_pulse,
               btn_shot_pulse, capture_done, uart_busy, uart_done,
        output trigger_enable, trigger_mask, edge_trigger, trigger_type, trigger_mode,
               cfg_changed, uart_start, clear_done, single_shot, cfg_channel,
               curr_cfg, state_o, export_err
    );
endinterface

// File: rtl/la_run_ctrl_cfg_bank.sv
// Per-channel trigger code bank: code registers, edit-channel counter and
// registered decode to mask/edge/type. Pulses arrive already edit-qualified.
module la_cfg_bank
    import la_ctrl_pkg::*;
#(
    parameter int NUM_CH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      type_pulse_i,
    input  logic                      chan_pulse_i,
    output logic [NUM_CH-1:0]         mask_o,
    output logic [NUM_CH-1:0]         edge_o,
    output logic [NUM_CH-1:0]         type_o,
    output logic [$clog2(NUM_CH)-1:0] idx_o,
    output logic [2:0]                curr_o
);
    localparam int IDX_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0][2:0] code_q, code_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_CH-1:0]      mask_q, edge_q, type_q;
    logic [2:0]             curr_q;

    // The type edit lands on the old index even when the channel advances too.
    always_comb begin
        code_d = code_q;
        idx_d  = idx_q;
        if (type_pulse_i)
            code_d[idx_q] = next_code(code_q[idx_q]);
        if (chan_pulse_i)
            idx_d = (idx_q == IDX_W'(NUM_CH - 1)) ? '0 : idx_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            code_q <= '0;
            idx_q  <= '0;
            mask_q <= '0;
            edge_q <= '0;
            type_q <= '0;
            curr_q <= '0;
        end else begin
            code_q <= code_d;
            idx_q  <= idx_d;
            curr_q <= code_d[idx_d];
            for (int i = 0; i < NUM_CH; i++) begin
                mask_q[i] <= code_d[i][0];
                type_q[i] <= code_d[i][1];
                edge_q[i] <= ~code_d[i][2];
            end
        end
    end

    assign mask_o = mask_q;
    assign edge_o = edge_q;
    assign type_o = type_q;
    assign idx_o  = idx_q;
    assign curr_o = curr_q;
endmodule

// File: rtl/la_run_ctrl.sv
// Run/stop, capture-export and re-arm sequencer for the logic analyzer.
// Optional export watchdog compiled in with LA_RUN_CTRL_WATCHDOG_EN.
module la_run_ctrl
    import la_ctrl_pkg::*;
#(
    parameter int          NUM_CH         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input logic         sys_clk,
    input logic         sys_rst_n,
    la_run_ctrl_if.slave bus
);
    if (NUM_CH < 2 || NUM_CH > 32 || TIMEOUT_CYCLES < 1) begin : g_param_err
        $error("la_run_ctrl: parameter out of range");
    end

    state_e     state_q;
    logic       trig_en_q;
    logic [1:0] mode_q;
    logic       cfg_changed_q;
    logic       uart_start_q;
    logic       clear_done_q;
    logic       single_shot_q;
    logic       stop_req_q;
    logic       uart_done_q;
    logic       edit_ok;
    logic       done_rise;
    logic       export_end;

    assign edit_ok   = (state_q != ST_EXPORT);
    assign done_rise = bus.uart_done & ~uart_done_q;

`ifdef LA_RUN_CTRL_WATCHDOG_EN
    logic [31:0] wd_cnt_q;
    logic        wd_timeout;
    logic        export_err_q;

    assign wd_timeout     = (wd_cnt_q == 32'(TIMEOUT_CYCLES - 1));
    assign export_end     = done_rise | wd_timeout;
    assign bus.export_err = export_err_q;
`else
    assign export_end     = done_rise;
    assign bus.export_err = 1'b0;
`endif

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q       <= ST_IDLE;
            trig_en_q     <= 1'b0;
            mode_q        <= TM_OR;
            cfg_changed_q <= 1'b0;
            uart_start_q  <= 1'b0;
            clear_done_q  <= 1'b0;
            single_shot_q <= 1'b0;
            stop_req_q    <= 1'b0;
            uart_done_q   <= 1'b0;
`ifdef LA_RUN_CTRL_WATCHDOG_EN
            wd_cnt_q      <= '0;
            export_err_q  <= 1'b0;
`endif
        end else begin
            uart_start_q  <= 1'b0;
            clear_done_q  <= 1'b0;
            uart_done_q   <= bus.uart_done;
            cfg_changed_q <= edit_ok & (bus.btn_type_pulse | bus.btn_mode_pulse);
            if (bus.btn_shot_pulse)
                single_shot_q <= ~single_shot_q;
            if (edit_ok && bus.btn_mode_pulse)
                mode_q <= (mode_q >= TM_AND_COIN) ? TM_OR : mode_q + 2'd1;

            case (state_q)
                ST_IDLE: begin
                    if (bus.btn_run_pulse) begin
                        state_q   <= ST_RUN;
                        trig_en_q <= 1'b1;
`ifdef LA_RUN_CTRL_WATCHDOG_EN
                        export_err_q <= 1'b0;
`endif
                    end
                end
                ST_RUN: begin
                    // Stop wins over a capture completing in the same cycle.
                    if (bus.btn_run_pulse) begin
                        state_q   <= ST_IDLE;
                        trig_en_q <= 1'b0;
                    end else if (bus.capture_done && !bus.uart_busy) begin
                        state_q      <= ST_EXPORT;
                        uart_start_q <= 1'b1;
`ifdef LA_RUN_CTRL_WATCHDOG_EN
                        wd_cnt_q     <= '0;
`endif
                    end
                end
                ST_EXPORT: begin
                    if (bus.btn_run_pulse)
                        stop_req_q <= 1'b1;
                    if (export_end) begin
                        clear_done_q <= 1'b1;
                        stop_req_q   <= 1'b0;
                        if (single_shot_q || stop_req_q || bus.btn_run_pulse) begin
                            state_q   <= ST_IDLE;
                            trig_en_q <= 1'b0;
                        end else begin
                            state_q <= ST_RUN;
                        end
`ifdef LA_RUN_CTRL_WATCHDOG_EN
                        if (!done_rise)
                            export_err_q <= 1'b1;
`endif
                    end
`ifdef LA_RUN_CTRL_WATCHDOG_EN
                    else begin
                        wd_cnt_q <= wd_cnt_q + 32'd1;
                    end
`endif
                end
                default: begin
                    state_q   <= ST_IDLE;
                    trig_en_q <= 1'b0;
                end
            endcase
        end
    end

    la_cfg_bank #(.NUM_CH(NUM_CH)) u_cfg_bank (
        .clk          (sys_clk),
        .rst_n        (sys_rst_n),
        .type_pulse_i (bus.btn_type_pulse & edit_ok),
        .chan_pulse_i (bus.btn_channel_pulse & edit_ok),
        .mask_o       (bus.trigger_mask),
        .edge_o       (bus.edge_trigger),
        .type_o       (bus.trigger_type),
        .idx_o        (bus.cfg_channel),
        .curr_o       (bus.curr_cfg)
    );

    assign bus.state_o        = state_q;
    assign bus.trigger_enable = trig_en_q;
    assign bus.trigger_mode   = mode_q;
    assign bus.cfg_changed    = cfg_changed_q;
    assign bus.uart_start     = uart_start_q;
    assign bus.clear_done     = clear_done_q;
    assign bus.single_shot    = single_shot_q;
endmodule

// File: tb/tb_la_run_ctrl.sv
// Scoreboard bench for la_run_ctrl: a rule-level model predicts every output
// per clock, a monitor pops and compares; directed plan plus random traffic.
module tb_la_run_ctrl;
    localparam int N  = 16;
    localparam int TO = 100;
`ifdef LA_RUN_CTRL_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    typedef struct {
        bit          ten;
        bit [N-1:0]  mask;
        bit [N-1:0]  edg;
        bit [N-1:0]  typ;
        bit [1:0]    mode;
        bit          cfgch;
        bit          ustart;
        bit          clr;
        bit          shot;
        bit [3:0]    ch;
        bit [2:0]    curr;
        bit [1:0]    st;
        bit          err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t sbq[$];

    la_run_ctrl_if #(.NUM_CH(N)) bus ();

    la_run_ctrl #(.NUM_CH(N), .TIMEOUT_CYCLES(TO)) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Reference model state, in terms of the spec's rules.
    int m_st, m_mode, m_idx, m_cnt;
    bit m_stop, m_shot, m_err, m_prev_done;
    int m_code[N];

    function automatic int nxt(input int c);
        int ord[5] = '{0, 1, 3, 5, 7};
        for (int i = 0; i < 5; i++)
            if (ord[i] == c) return ord[(i + 1) % 5];
        return 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit rst, input bit run, input bit chan, input bit typ,
                        input bit mode, input bit shot, input bit cap, input bit busy,
                        input bit done);
        exp_t e;
        bit   rise, edit, old_shot, fin, tmo;
        @(negedge clk);
        rst_n                 = ~rst;
        bus.btn_run_pulse     = run;
        bus.btn_channel_pulse = chan;
        bus.btn_type_pulse    = typ;
        bus.btn_mode_pulse    = mode;
        bus.btn_shot_pulse    = shot;
        bus.capture_done      = cap;
        bus.uart_busy         = busy;
        bus.uart_done         = done;
        e = '{default: 0};
        if (rst) begin
            m_st = 0; m_mode = 0; m_idx = 0; m_cnt = 0;
            m_stop = 0; m_shot = 0; m_err = 0; m_prev_done = 0;
            foreach (m_code[i]) m_code[i] = 0;
        end else begin
            rise = done && !m_prev_done;
            m_prev_done = done;
            edit = (m_st != 2);
            e.cfgch = edit && (typ || mode);
            if (edit && typ)  m_code[m_idx] = nxt(m_code[m_idx]);
            if (edit && mode) m_mode = (m_mode + 1) % 3;
            if (edit && chan) m_idx = (m_idx + 1) % N;
            old_shot = m_shot;
            if (shot) m_shot = !m_shot;
            case (m_st)
                0: if (run) begin m_st = 1; m_err = 0; end
                1: if (run) m_st = 0;
                   else if (cap && !busy) begin m_st = 2; e.ustart = 1; m_cnt = 0; end
                default: begin
                    if (run) m_stop = 1;
                    tmo = WD && !rise && (m_cnt == TO - 1);
                    fin = rise || tmo;
                    if (fin) begin
                        e.clr = 1;
                        if (tmo) m_err = 1;
                        m_st = (old_shot || m_stop) ? 0 : 1;
                        m_stop = 0;
                    end else m_cnt++;
                end
            endcase
            e.ten = (m_st != 0);
            e.mode = 2'(m_mode);
            e.shot = m_shot;
            e.ch = 4'(m_idx);
            e.curr = 3'(m_code[m_idx]);
            e.st = 2'(m_st);
            e.err = m_err;
            for (int i = 0; i < N; i++) begin
                e.mask[i] = m_code[i][0];
                e.typ[i]  = m_code[i][1];
                e.edg[i]  = !m_code[i][2];
            end
        end
        sbq.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: every clock the DUT presents a full output set.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("trigger_enable", 32'(bus.trigger_enable), 32'(e.ten));
                chk("trigger_mask",   32'(bus.trigger_mask),   32'(e.mask));
                chk("edge_trigger",   32'(bus.edge_trigger),   32'(e.edg));
                chk("trigger_type",   32'(bus.trigger_type),   32'(e.typ));
                chk("trigger_mode",   32'(bus.trigger_mode),   32'(e.mode));
                chk("cfg_changed",    32'(bus.cfg_changed),    32'(e.cfgch));
                chk("uart_start",     32'(bus.uart_start),     32'(e.ustart));
                chk("clear_done",     32'(bus.clear_done),     32'(e.clr));
                chk("single_shot",    32'(bus.single_shot),    32'(e.shot));
                chk("cfg_channel",    32'(bus.cfg_channel),    32'(e.ch));
                chk("curr_cfg",       32'(bus.curr_cfg),       32'(e.curr));
                chk("state_o",        32'(bus.state_o),        32'(e.st));
                chk("export_err",     32'(bus.export_err),     32'(e.err));
            end
        end
    end

    initial begin
        bus.btn_run_pulse = 0; bus.btn_channel_pulse = 0; bus.btn_type_pulse = 0;
        bus.btn_mode_pulse = 0; bus.btn_shot_pulse = 0; bus.capture_done = 0;
        bus.uart_busy = 0; bus.uart_done = 0;

        // Reset state
        repeat (3) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        chk("rst_state", 32'(bus.state_o), 0);
        chk("rst_edge", 32'(bus.edge_trigger), 0);
        idle(1);

        // Run pulse -> enable after one clock
        step(0, 1, 0, 0, 0, 0, 0, 0, 0); settle();
        chk("run_ten", 32'(bus.trigger_enable), 1);
        chk("run_state", 32'(bus.state_o), 1);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);

        // 15 channel pulses then a type pulse on channel 15
        repeat (15) step(0, 0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0, 0); settle();
        chk("ch15_idx", 32'(bus.cfg_channel), 15);
        chk("ch15_mask", 32'(bus.trigger_mask), 32'h8000);
        chk("ch15_edge", 32'(bus.edge_trigger[15]), 1);
        chk("ch15_cfgch", 32'(bus.cfg_changed), 1);
        step(0, 0, 1, 0, 0, 0, 0, 0, 0); settle();
        chk("wrap_idx", 32'(bus.cfg_channel), 0);
        chk("cfgch_once", 32'(bus.cfg_changed), 0);

        // Continuous: capture held while streamer busy
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        repeat (10) step(0, 0, 0, 0, 0, 0, 1, 1, 0);
        settle();
        chk("busy_hold", 32'(bus.uart_start), 0);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0); settle();
        chk("ustart", 32'(bus.uart_start), 1);
        chk("exp_state", 32'(bus.state_o), 2);
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        settle();
        chk("ustart_once", 32'(bus.uart_start), 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1); settle();
        chk("clr_cont", 32'(bus.clear_done), 1);
        chk("back_run", 32'(bus.state_o), 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Single-shot, with a locked type edit during export
        step(0, 0, 0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0, 0); settle();
        chk("lock_curr", 32'(bus.curr_cfg), 32'b001);
        chk("lock_cfgch", 32'(bus.cfg_changed), 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1); settle();
        chk("ss_clr", 32'(bus.clear_done), 1);
        chk("ss_idle", 32'(bus.state_o), 0);
        chk("ss_ten", 32'(bus.trigger_enable), 0);
        step(0, 0, 0, 0, 0, 1, 0, 0, 0);

        // Stop request during export
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(3); settle();
        chk("stop_hold", 32'(bus.state_o), 2);
        chk("stop_ten", 32'(bus.trigger_enable), 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1); settle();
        chk("stop_clr", 32'(bus.clear_done), 1);
        chk("stop_idle", 32'(bus.state_o), 0);
        idle(1);

        // Export with uart_done withheld
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(TO - 1); settle();
        chk("wd_early", 32'(bus.clear_done), 0);
        idle(1); settle();
`ifdef LA_RUN_CTRL_WATCHDOG_EN
        chk("wd_clr", 32'(bus.clear_done), 1);
        chk("wd_err", 32'(bus.export_err), 1);
        chk("wd_run", 32'(bus.state_o), 1);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0); settle();
        chk("wd_errclr", 32'(bus.export_err), 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
`else
        chk("nowd_err", 32'(bus.export_err), 0);
        chk("nowd_state", 32'(bus.state_o), 2);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
`endif

        // Random traffic, including occasional reset mid-flight
        for (int i = 0; i < 3000; i++)
            step($urandom_range(299) == 0, $urandom_range(19) == 0, $urandom_range(5) == 0,
                 $urandom_range(5) == 0, $urandom_range(9) == 0, $urandom_range(29) == 0,
                 $urandom_range(3) != 0, $urandom_range(2) == 0, $urandom_range(7) == 0);

        idle(2);
        repeat (4) @(posedge clk);
        #3;
        chk("sb_drain", 32'(sbq.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
